// File: rtl/beam_sum_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : beam_sum_i2s_tx                                              |
// | Description : Beamformer output stage. Sums one set of per-channel PCM     |
// |               samples, applies a programmable arithmetic right shift,     |
// |               saturates to the sample width and serialises the result as  |
// |               a mono I2S stream (same word in left and right half-frames).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module beam_sum_i2s_tx #(
  parameter int NUMBER_OF_BITS   = 16,
  parameter int NUMBER_OF_INPUTS = 8,
  parameter int HALF_FRAME_BITS  = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic [NUMBER_OF_INPUTS*NUMBER_OF_BITS-1:0] samples_in,
  input  logic                                       sample_valid,
  input  logic [2:0]                                 gain_shift,
  input  logic                                       clear_flags,
  output logic                                       sd_out,
  output logic                                       ws_out,
  output logic                                       frame_start,
  output logic                                       sat_flag,
  output logic                                       overrun_flag,
  output logic                                       underrun_flag
);

  // Sum width is wide enough that adding all inputs can never overflow.
  localparam int SUM_W = NUMBER_OF_BITS + $clog2(NUMBER_OF_INPUTS);
  localparam int CNT_W = $clog2(HALF_FRAME_BITS);
  localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'((1 <<< (NUMBER_OF_BITS - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;
  localparam logic [NUMBER_OF_BITS-1:0] C_WORD_MAX = {1'b0, {(NUMBER_OF_BITS-1){1'b1}}};
  localparam logic [NUMBER_OF_BITS-1:0] C_WORD_MIN = {1'b1, {(NUMBER_OF_BITS-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic                       sum_valid_q, sum_valid_d;
  logic [NUMBER_OF_BITS-1:0]  holding_q, holding_d;
  logic                       pending_q, pending_d;
  logic [CNT_W-1:0]           bit_count_q, bit_count_d;
  logic                       ws_q, ws_d;
  logic                       sd_q, sd_d;
  logic                       frame_start_q, frame_start_d;
  logic [NUMBER_OF_BITS-1:0]  shreg_q, shreg_d;
  logic [NUMBER_OF_BITS-1:0]  word_q, word_d;
  logic                       sat_q, sat_d;
  logic                       overrun_q, overrun_d;
  logic                       underrun_q, underrun_d;

  logic                       load_left;
  logic                       load_right;
  logic signed [SUM_W-1:0]    shifted;
  logic [NUMBER_OF_BITS-1:0]  clamped;
  logic                       clamp_hit;

  // Stage 1: sign-extend every input and add them all into one register.
  always_comb begin
    sum_valid_d = sample_valid;
    sum_d       = sum_q;
    if (sample_valid) begin
      sum_d = '0;
      for (int k = 0; k < NUMBER_OF_INPUTS; k++) begin
        sum_d = sum_d + {{(SUM_W-NUMBER_OF_BITS){samples_in[k*NUMBER_OF_BITS+NUMBER_OF_BITS-1]}},
                         samples_in[k*NUMBER_OF_BITS +: NUMBER_OF_BITS]};
      end
    end
  end

  // Serializer: half-frame counter, word select, load events and bit shifting.
  always_comb begin
    state_d       = state_q;
    bit_count_d   = bit_count_q;
    ws_d          = ws_q;
    sd_d          = 1'b0;
    frame_start_d = 1'b0;
    shreg_d       = shreg_q;
    word_d        = word_q;
    load_left     = 1'b0;
    load_right    = 1'b0;
    if (!enable) begin
      state_d     = ST_IDLE;
      bit_count_d = '0;
      ws_d        = 1'b0;
    end else if (state_q == ST_IDLE) begin
      // First enabled cycle is always the start of a left half-frame.
      state_d     = ST_RUN;
      bit_count_d = '0;
      ws_d        = 1'b0;
      load_left   = 1'b1;
    end else if (bit_count_q == CNT_W'(HALF_FRAME_BITS - 1)) begin
      bit_count_d = '0;
      ws_d        = ~ws_q;
      load_left   = ws_q;
      load_right  = ~ws_q;
    end else begin
      bit_count_d = bit_count_q + CNT_W'(1);
    end

    if (load_left) begin
      // Old holding value: a same-cycle stage-2 write lands after this load.
      shreg_d       = holding_q;
      word_d        = holding_q;
      frame_start_d = 1'b1;
    end else if (load_right) begin
      shreg_d = word_q;
    end else if (enable && bit_count_d >= CNT_W'(1) &&
                 bit_count_d <= CNT_W'(NUMBER_OF_BITS)) begin
      // Bit 0 of each half is the I2S one-bit delay, so shifting starts at 1.
      sd_d    = shreg_q[NUMBER_OF_BITS-1];
      shreg_d = {shreg_q[NUMBER_OF_BITS-2:0], 1'b0};
    end
  end

  // Stage 2: scale, saturate, update the holding slot and the sticky flags.
  always_comb begin
    shifted   = sum_q >>> gain_shift;
    clamp_hit = 1'b0;
    clamped   = shifted[NUMBER_OF_BITS-1:0];
    if (shifted > C_MAX) begin
      clamped   = C_WORD_MAX;
      clamp_hit = 1'b1;
    end else if (shifted < C_MIN) begin
      clamped   = C_WORD_MIN;
      clamp_hit = 1'b1;
    end

    holding_d = sum_valid_q ? clamped : holding_q;
    if (sum_valid_q) begin
      pending_d = 1'b1;
    end else if (load_left) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    // An unsent word is only lost if the load did not take it this cycle.
    sat_d      = (sum_valid_q && clamp_hit) | (sat_q & ~clear_flags);
    overrun_d  = (sum_valid_q && pending_q && !load_left) | (overrun_q & ~clear_flags);
    underrun_d = (load_left && !pending_q) | (underrun_q & ~clear_flags);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sum_q         <= '0;
      sum_valid_q   <= 1'b0;
      holding_q     <= '0;
      pending_q     <= 1'b0;
      bit_count_q   <= '0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      shreg_q       <= '0;
      word_q        <= '0;
      sat_q         <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      sum_valid_q   <= sum_valid_d;
      holding_q     <= holding_d;
      pending_q     <= pending_d;
      bit_count_q   <= bit_count_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      shreg_q       <= shreg_d;
      word_q        <= word_d;
      sat_q         <= sat_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sd_out        = sd_q;
  assign ws_out        = ws_q;
  assign frame_start   = frame_start_q;
  assign sat_flag      = sat_q;
  assign overrun_flag  = overrun_q;
  assign underrun_flag = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_sum_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_beam_sum_i2s_tx                                           |
// | Description : Self-checking bench for beam_sum_i2s_tx: table vectors,      |
// |               frame timing, overrun/underrun, mid-frame reset and random  |
// |               traffic against a frame-level reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_beam_sum_i2s_tx;

  localparam int N   = 16;
  localparam int NI  = 8;
  localparam int HFB = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [NI*N-1:0] samples_in = '0;
  logic           sample_valid = 1'b0;
  logic [2:0]     gain_shift = 3'd0;
  logic           clear_flags = 1'b0;
  logic           sd_out, ws_out, frame_start, sat_flag, overrun_flag, underrun_flag;

  int checks = 0;
  int errors = 0;

  beam_sum_i2s_tx #(
    .NUMBER_OF_BITS  (N),
    .NUMBER_OF_INPUTS(NI),
    .HALF_FRAME_BITS (HFB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .samples_in   (samples_in),
    .sample_valid (sample_valid),
    .gain_shift   (gain_shift),
    .clear_flags  (clear_flags),
    .sd_out       (sd_out),
    .ws_out       (ws_out),
    .frame_start  (frame_start),
    .sat_flag     (sat_flag),
    .overrun_flag (overrun_flag),
    .underrun_flag(underrun_flag)
  );

  always #5 clk = ~clk;

  // Reference model: pipeline as delayed integers, serializer as a phase
  // counter within a 2*HFB-cycle frame.
  int m_s1v, m_s1sum, m_hold, m_pend, m_run, m_phase, m_word;
  bit m_sat, m_ovr, m_und, m_sd, m_ws, m_fs;

  task automatic model_update();
    int  sum, v, b, new_word;
    bit  load, wr, clip;
    if (reset) begin
      m_s1v = 0; m_s1sum = 0; m_hold = 0; m_pend = 0; m_run = 0; m_phase = 0; m_word = 0;
      m_sat = 0; m_ovr = 0; m_und = 0; m_sd = 0; m_ws = 0; m_fs = 0;
      return;
    end
    load = enable && (m_run == 0 || m_phase == 2*HFB - 1);
    wr   = (m_s1v != 0);
    v    = m_s1sum >>> gain_shift;
    clip = 0;
    if (v > 32767) begin v = 32767; clip = 1; end
    else if (v < -32768) begin v = -32768; clip = 1; end
    m_sat = (wr && clip) | (m_sat & !clear_flags);
    m_ovr = (wr && m_pend != 0 && !load) | (m_ovr & !clear_flags);
    m_und = (load && m_pend == 0) | (m_und & !clear_flags);
    new_word = load ? m_hold : m_word;
    m_pend = wr ? 1 : (load ? 0 : m_pend);
    m_hold = wr ? (v & 16'hFFFF) : m_hold;
    m_word = new_word;
    sum = 0;
    for (int k = 0; k < NI; k++) sum += $signed(samples_in[k*N +: N]);
    m_s1v = sample_valid;
    if (sample_valid) m_s1sum = sum;
    if (!enable) begin
      m_run = 0; m_phase = 0; m_sd = 0; m_ws = 0; m_fs = 0;
    end else begin
      m_phase = load ? 0 : m_phase + 1;
      m_run = 1;
      b = m_phase % HFB;
      m_ws = ((m_phase / HFB) % 2) != 0;
      m_sd = (b >= 1 && b <= N) ? (((m_word >> (N - b)) & 1) != 0) : 1'b0;
      m_fs = (m_phase == 0);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update model from current inputs, clock DUT, compare.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("model", {26'd0, sd_out, ws_out, frame_start, sat_flag, overrun_flag, underrun_flag},
                   {26'd0, m_sd, m_ws, m_fs, m_sat, m_ovr, m_und});
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NI*N-1:0] samples;
    logic [2:0]      gain;
    logic [N-1:0]    exp_word;
    logic            exp_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] left, right, w1, w2;
    int           last_fs, fs_cnt, bad_ws, bad_tail, bad_msb, bad_fs;

    vecs[0] = '{ {8{16'h1000}}, 3'd0, 16'h7FFF, 1'b1 };
    vecs[1] = '{ {8{16'h1000}}, 3'd3, 16'h1000, 1'b0 };
    vecs[2] = '{ {8{16'h8000}}, 3'd3, 16'h8000, 1'b0 };
    vecs[3] = '{ {96'd0, 16'hFFCE, 16'h0064}, 3'd0, 16'h0032, 1'b0 };
    vecs[4] = '{ {8{16'h7FFF}}, 3'd3, 16'h7FFF, 1'b0 };
    vecs[5] = '{ {8{16'h8000}}, 3'd2, 16'h8000, 1'b1 };
    vecs[6] = '{ {8{16'hFFFF}}, 3'd7, 16'hFFFF, 1'b0 };
    vecs[7] = '{ {96'd0, 16'h4000, 16'h4000}, 3'd1, 16'h4000, 1'b0 };

    // Reset state.
    do_reset();
    check("reset_outputs", {26'd0, sd_out, ws_out, frame_start, sat_flag, overrun_flag, underrun_flag}, 32'd0);

    // Table vectors: load one sample, then transmit one full frame.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      samples_in = vecs[i].samples;
      gain_shift = vecs[i].gain;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      step();
      step();
      enable = 1'b1;
      left = '0; right = '0;
      for (int k = 0; k < 2*HFB; k++) begin
        step();
        if (k >= 1 && k <= N) left = {left[N-2:0], sd_out};
        if (k >= HFB + 1 && k <= HFB + N) right = {right[N-2:0], sd_out};
      end
      check($sformatf("vec%0d_left", i), left, vecs[i].exp_word);
      check($sformatf("vec%0d_right", i), right, vecs[i].exp_word);
      check($sformatf("vec%0d_sat", i), sat_flag, vecs[i].exp_sat);
      check($sformatf("vec%0d_underrun", i), underrun_flag, 0);
      enable = 1'b0;
      step();
    end

    // Frame timing over three frames with word 0xFFFF.
    do_reset();
    samples_in = {112'd0, 16'hFFFF};
    gain_shift = 3'd0;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    enable = 1'b1;
    last_fs = -1; fs_cnt = 0; bad_ws = 0; bad_tail = 0; bad_msb = 0; bad_fs = 0;
    for (int k = 0; k < 3*2*HFB; k++) begin
      step();
      if (ws_out !== (((k / HFB) % 2) != 0)) bad_ws++;
      if ((k % HFB) > N && sd_out !== 1'b0) bad_tail++;
      if ((k % HFB) == 0 && sd_out !== 1'b0) bad_tail++;
      if ((k % HFB) == 1 && sd_out !== 1'b1) bad_msb++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0 && k - last_fs != 2*HFB) bad_fs++;
        last_fs = k;
        fs_cnt++;
      end
    end
    check("ws_period", bad_ws, 0);
    check("sd_tail_zero", bad_tail, 0);
    check("msb_after_ws", bad_msb, 0);
    check("fs_spacing", bad_fs, 0);
    check("fs_count", fs_cnt, 3);
    enable = 1'b0;
    step();
    check("idle_outputs", {29'd0, sd_out, ws_out, frame_start}, 32'd0);

    // Overrun then underrun then clear.
    do_reset();
    gain_shift = 3'd0;
    enable = 1'b1;
    w1 = '0; w2 = '0;
    for (int k = 0; k <= 144; k++) begin
      clear_flags  = (k == 1);
      sample_valid = (k == 5 || k == 6);
      samples_in   = (k == 6) ? {112'd0, 16'h1234} : {8{16'h0100}};
      step();
      if (k == 64) begin
        check("overrun_set", overrun_flag, 1);
        check("no_underrun_on_pending", underrun_flag, 0);
      end
      if (k >= 65 && k <= 64 + N) w1 = {w1[N-2:0], sd_out};
      if (k == 128) check("underrun_set", underrun_flag, 1);
      if (k >= 129 && k <= 128 + N) w2 = {w2[N-2:0], sd_out};
    end
    check("overrun_word", w1, 16'h1234);
    check("repeat_word", w2, 16'h1234);
    sample_valid = 1'b0;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("flags_cleared", {29'd0, sat_flag, overrun_flag, underrun_flag}, 32'd0);

    // Reset at bit_count 9 with a pending word.
    do_reset();
    enable = 1'b1;
    samples_in = {112'd0, 16'h0ABC};
    for (int k = 0; k <= 9; k++) begin
      sample_valid = (k == 2);
      step();
    end
    reset = 1'b1;
    step();
    check("midreset_outputs", {26'd0, sd_out, ws_out, frame_start, sat_flag, overrun_flag, underrun_flag}, 32'd0);
    reset = 1'b0;
    w1 = 16'hFFFF;
    for (int k = 0; k <= N; k++) begin
      step();
      if (k == 0) begin
        check("postreset_fs", frame_start, 1);
        check("postreset_underrun", underrun_flag, 1);
      end
      if (k >= 1) w1 = {w1[N-2:0], sd_out};
    end
    check("postreset_word", w1, 16'h0000);

    // Random traffic against the model.
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      sample_valid = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NI; k++) samples_in[k*N +: N] = 16'($urandom);
      gain_shift  = 3'($urandom_range(0, 7));
      clear_flags = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
